// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants, types and anode decode for the display scanner
//
// Purpose : digit count, nibble width, default prescaler width, blank and
//           active-low enable constants, and the anode decode helper.
// Ports   : none (package).
package disp_pkg;

  localparam int NDIG      = 4;
  localparam int NIB_W     = 4;
  localparam int DIV_W_DEF = 17;

  localparam logic [NDIG-1:0] BLANK_NONE = 4'b0000;
  localparam logic [NDIG-1:0] AN_ALL_OFF = 4'b1111;
  localparam logic            AN_ON      = 1'b0;

  typedef logic [1:0] sel_t;

  // Staging and active registers carry digits and blank mask together.
  typedef struct packed {
    logic [NDIG*NIB_W-1:0] digits;
    logic [NDIG-1:0]       blank;
  } disp_word_t;

  localparam disp_word_t DISP_WORD_RST = '{digits: '0, blank: BLANK_NONE};

  // One enable low for the selected digit, unless that digit is blanked.
  function automatic logic [NDIG-1:0] an_decode(input sel_t sel, input logic [NDIG-1:0] blank);
    logic [NDIG-1:0] w_an;
    w_an = AN_ALL_OFF;
    if (!blank[sel]) begin
      w_an[sel] = AN_ON;
    end
    return w_an;
  endfunction

endpackage

// File: rtl/disp_scan_tick_gen.sv
// rtl/disp_scan_tick_gen.sv - free-running prescaler producing the scan tick
//
// Purpose : DIV_W-bit wrapping counter; tick is high in the cycle where the
//           counter is all ones, i.e. once every 2^DIV_W cycles.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset (counter to 0)
//           tick - scan step strobe
module tick_gen #(
  parameter int DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = &r_cnt;

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - four-digit multiplexed display scanner with frame-aligned commit
//
// Purpose : steps a 2-bit scan select every prescaler tick, decodes active-low
//           digit enables, and double-buffers digit data so the displayed
//           digits only change at the frame boundary (s wrapping 3 -> 0).
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           load            - strobe capturing din/blank_in into staging
//           din[15:0]       - four hex digits, [3:0] is digit 0
//           blank_in[3:0]   - per-digit blank mask
//           s[1:0]          - scan select for the downstream nibble mux
//           I0..I3[3:0]     - active digit nibbles 0..3
//           an[3:0]         - active-low digit enables
//           pending         - staging holds uncommitted data
//           frame           - one-cycle pulse after each completed frame
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NDIG*NIB_W-1:0] din,
  input  logic [NDIG-1:0]       blank_in,
  output logic [1:0]            s,
  output logic [NIB_W-1:0]      I0,
  output logic [NIB_W-1:0]      I1,
  output logic [NIB_W-1:0]      I2,
  output logic [NIB_W-1:0]      I3,
  output logic [NDIG-1:0]       an,
  output logic                  pending,
  output logic                  frame
);

  localparam sel_t SEL_LAST = 2'd3;

  logic       w_tick;
  logic       w_commit;
  sel_t       r_s;
  disp_word_t r_stage;
  disp_word_t r_active;
  logic       r_pending;
  logic       r_frame;

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // The last digit slot finishing is the only point active data may change.
  assign w_commit = w_tick && (r_s == SEL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= '0;
    end else if (w_tick) begin
      r_s <= r_s + 2'd1;
    end
  end

  // Load wins over the commit clear: a load on the commit edge leaves new
  // data staged while the previous staging moves to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage   <= DISP_WORD_RST;
      r_pending <= 1'b0;
    end else if (load) begin
      r_stage   <= '{digits: din, blank: blank_in};
      r_pending <= 1'b1;
    end else if (w_commit) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= DISP_WORD_RST;
    end else if (w_commit && r_pending) begin
      r_active <= r_stage;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_commit;
    end
  end

  assign s       = r_s;
  assign an      = an_decode(r_s, r_active.blank);
  assign I0      = r_active.digits[3:0];
  assign I1      = r_active.digits[7:4];
  assign I2      = r_active.digits[11:8];
  assign I3      = r_active.digits[15:12];
  assign pending = r_pending;
  assign frame   = r_frame;

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - self-checking bench for disp_scan with DIV_W=2
module tb_disp_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  blank_in;
  logic [1:0]  s;
  logic [3:0]  I0, I1, I2, I3;
  logic [3:0]  an;
  logic        pending;
  logic        frame;

  int n_checks;
  int n_errors;

  disp_scan #(.DIV_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .blank_in (blank_in),
    .s        (s),
    .I0       (I0),
    .I1       (I1),
    .I2       (I2),
    .I3       (I3),
    .an       (an),
    .pending  (pending),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: everything derives from the number of edges since reset.
  // A scan step is 4 edges, a frame is 16 edges; commit on the 16k-th edge.
  int          m_cyc;
  logic [15:0] m_stage, m_active;
  logic [3:0]  m_stage_bl, m_active_bl;
  logic        m_pending;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_stage = 0; m_active = 0;
      m_stage_bl = 0; m_active_bl = 0; m_pending = 0;
    end else begin
      if ((m_cyc % 16) == 15 && m_pending) begin
        m_active    = m_stage;
        m_active_bl = m_stage_bl;
        m_pending   = 0;
      end
      if (load) begin
        m_stage    = din;
        m_stage_bl = blank_in;
        m_pending  = 1;
      end
      m_cyc = m_cyc + 1;
    end
  end

  function automatic int exp_s();
    return (m_cyc / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an();
    int k;
    k = exp_s();
    if (m_active_bl[k]) return 4'b1111;
    return 4'b1111 & ~(4'b0001 << k);
  endfunction

  function automatic logic exp_frame();
    return (m_cyc > 0) && ((m_cyc % 16) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, m_cyc);
    end
  endtask

  // Per-cycle comparison against the model, a little after the falling edge.
  bit cmp_en = 0;
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("m_s",       {30'd0, s},             exp_s());
      chk("m_an",      {28'd0, an},            {28'd0, exp_an()});
      chk("m_digits",  {16'd0, I3, I2, I1, I0}, {16'd0, m_active});
      chk("m_pending", {31'd0, pending},       {31'd0, m_pending});
      chk("m_frame",   {31'd0, frame},         {31'd0, exp_frame()});
    end
  end

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (m_cyc != target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cyc_reached", m_cyc, target);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    load = 1'b1; din = d; blank_in = b;
    @(negedge clk);
    load = 1'b0; din = $urandom; blank_in = $urandom;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; load = 1'b0; din = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", {28'd0, an}, 32'he);
    chk("rst_digits", {16'd0, I3, I2, I1, I0}, 32'h0);
    rst = 1'b0;
    cmp_en = 1;

    // Free run: literal pins of the scan sequence and first frame pulse.
    chk("run_s0", {30'd0, s}, 0);
    wait_cyc(4);  chk("run_an1", {28'd0, an}, 32'hd);
    wait_cyc(8);  chk("run_an2", {28'd0, an}, 32'hb);
    wait_cyc(12); chk("run_an3", {28'd0, an}, 32'h7);
    wait_cyc(15); chk("run_frame_lo", {31'd0, frame}, 0);
    wait_cyc(16); chk("run_frame_hi", {31'd0, frame}, 1);
    chk("run_s_wrap", {30'd0, s}, 0);

    // Load while s=1: staged but not displayed until the wrap.
    wait_cyc(20);
    do_load(16'h1234, 4'b0000);
    chk("ld_pending", {31'd0, pending}, 1);
    chk("ld_hold", {16'd0, I3, I2, I1, I0}, 32'h0);
    wait_cyc(31); chk("ld_hold_late", {16'd0, I3, I2, I1, I0}, 32'h0);
    wait_cyc(32);
    chk("ld_commit", {16'd0, I3, I2, I1, I0}, 32'h1234);
    chk("ld_pending_clr", {31'd0, pending}, 0);
    chk("ld_frame", {31'd0, frame}, 1);

    // Last load wins; load on the commit edge stages for the next frame.
    wait_cyc(36); do_load(16'hAAAA, 4'b0000);
    wait_cyc(40); do_load(16'h5A5A, 4'b0000);
    wait_cyc(47); do_load(16'h9876, 4'b0000);
    chk("lw_commit", {16'd0, I3, I2, I1, I0}, 32'h5a5a);
    chk("lw_pending", {31'd0, pending}, 1);
    wait_cyc(64);
    chk("lw_next", {16'd0, I3, I2, I1, I0}, 32'h9876);
    chk("lw_pending_clr", {31'd0, pending}, 0);

    // Blanked digits 0 and 2.
    wait_cyc(66); do_load(16'hFFFF, 4'b0101);
    wait_cyc(80); chk("bl_an0", {28'd0, an}, 32'hf);
    wait_cyc(84); chk("bl_an1", {28'd0, an}, 32'hd);
    wait_cyc(88); chk("bl_an2", {28'd0, an}, 32'hf);
    wait_cyc(92); chk("bl_an3", {28'd0, an}, 32'h7);

    // Reset while a load is pending at s=2: immediate clear, load lost.
    wait_cyc(96); do_load(16'h4321, 4'b0000);
    wait_cyc(104);
    #3 rst = 1'b1;
    #1;
    chk("ar_s", {30'd0, s}, 0);
    chk("ar_an", {28'd0, an}, 32'he);
    chk("ar_digits", {16'd0, I3, I2, I1, I0}, 32'h0);
    chk("ar_pending", {31'd0, pending}, 0);
    chk("ar_frame", {31'd0, frame}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(17);
    chk("ar_lost", {16'd0, I3, I2, I1, I0}, 32'h0);
    chk("ar_lost_pend", {31'd0, pending}, 0);

    // Random traffic, occasional async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load     = ($urandom_range(0, 5) == 0);
      din      = $urandom;
      blank_in = $urandom;
      if ($urandom_range(0, 400) == 0) begin
        #3 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    load = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
